// File: rtl/ps2_responses_pkg.sv
// rtl/ps2_responses_pkg.sv - shared PS/2 byte constants, lock scan codes and sequence states
package ps2_package;

    localparam logic [7:0] ACK             = 8'hFA;
    localparam logic [7:0] RESEND          = 8'hFE;
    localparam logic [7:0] BAT_OK          = 8'hAA;
    localparam logic [7:0] BAT_FAIL_0      = 8'hFC;
    localparam logic [7:0] BAT_FAIL_1      = 8'hFD;
    localparam logic [7:0] OVERRUN_0       = 8'h00;
    localparam logic [7:0] OVERRUN_1       = 8'hFF;
    localparam logic [7:0] PREFIX_EXTENDED = 8'hE0;
    localparam logic [7:0] PREFIX_PAUSE    = 8'hE1;
    localparam logic [7:0] PREFIX_BREAK    = 8'hF0;
    localparam logic [7:0] SET_STATUS      = 8'hED;

    localparam logic [7:0] CAPS_LOCK_CODE   = 8'h58;
    localparam logic [7:0] NUM_LOCK_CODE    = 8'h77;
    localparam logic [7:0] SCROLL_LOCK_CODE = 8'h7E;

    // Bytes remaining in the Pause sequence after its 0xE1 lead-in
    localparam logic [2:0] PAUSE_SKIP_COUNT = 3'd7;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_EXT,
        SEQ_BRK,
        SEQ_EXT_BRK,
        SEQ_SKIP
    } seq_state_t;

endpackage

// File: rtl/ps2_responses_if.sv
// rtl/ps2_responses_if.sv - receive-byte and key-event bundle of the PS/2 response interpreter
interface ps2_responses_if;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic       rx_error;
    logic       acknowledge;
    logic       resend;
    logic       set_status;
    logic       set_status_caps_lock;
    logic       set_status_num_lock;
    logic       set_status_scroll_lock;
    logic       bat_error;
    logic       receive_error;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;

    modport master (
        output rx_valid, rx_byte, rx_error, key_ready,
        input  rx_ready, acknowledge, resend, set_status,
        input  set_status_caps_lock, set_status_num_lock, set_status_scroll_lock,
        input  bat_error, receive_error, key_valid, key_code, key_extended, key_release
    );

    modport slave (
        input  rx_valid, rx_byte, rx_error, key_ready,
        output rx_ready, acknowledge, resend, set_status,
        output set_status_caps_lock, set_status_num_lock, set_status_scroll_lock,
        output bat_error, receive_error, key_valid, key_code, key_extended, key_release
    );
endinterface

// File: rtl/ps2_responses_lock_key.sv
// rtl/ps2_responses_lock_key.sv - one lock level with typematic-repeat suppression
module ps2_lock_key (
    input  logic clk,
    input  logic reset_low,
    input  logic make_i,
    input  logic break_i,
    output logic level_o,
    output logic toggle_o
);
    logic level_q;
    logic held_q;

    // Only the first make of a press flips the lock; repeats arrive while held
    assign toggle_o = make_i && !held_q;
    assign level_o  = level_q;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            level_q <= 1'b0;
            held_q  <= 1'b0;
        end else if (toggle_o) begin
            level_q <= ~level_q;
            held_q  <= 1'b1;
        end else if (break_i) begin
            held_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/ps2_responses.sv
// rtl/ps2_responses.sv - decodes PS/2 keyboard bytes into response strobes, key events and lock state
module ps2_responses
    import ps2_package::*;
(
    input  logic           clk,
    input  logic           reset_low,
    ps2_responses_if.slave ps2
);
    seq_state_t state_q;
    logic [2:0] skip_q;
    logic       ack_q, resend_q, set_status_q, bat_error_q, receive_error_q;
    logic       key_valid_q, key_extended_q, key_release_q;
    logic [7:0] key_code_q;

    logic       accept, good, idle, is_response, is_prefix;
    logic       event_d, ext_d, rel_d, lock_hit;
    logic [2:0] lock_make, lock_break, lock_toggle, lock_level;
    logic [7:0] rx_byte;

    assign rx_byte      = ps2.rx_byte;
    assign ps2.rx_ready = !key_valid_q || ps2.key_ready;

    always_comb begin
        accept      = ps2.rx_valid && ps2.rx_ready;
        good        = accept && !ps2.rx_error;
        idle        = (state_q == SEQ_IDLE);
        // Response bytes only mean something outside a make/break sequence
        is_response = idle && (rx_byte inside {ACK, RESEND, BAT_OK, BAT_FAIL_0, BAT_FAIL_1,
                                               OVERRUN_0, OVERRUN_1});
        is_prefix   = (idle && (rx_byte inside {PREFIX_EXTENDED, PREFIX_BREAK, PREFIX_PAUSE}))
                   || ((state_q == SEQ_EXT) && (rx_byte == PREFIX_BREAK));
        event_d     = good && (state_q != SEQ_SKIP) && !is_response && !is_prefix;
        ext_d       = (state_q == SEQ_EXT) || (state_q == SEQ_EXT_BRK);
        rel_d       = (state_q == SEQ_BRK) || (state_q == SEQ_EXT_BRK);
        lock_hit    = event_d && !ext_d;
        lock_make[0]  = lock_hit && !rel_d && (rx_byte == CAPS_LOCK_CODE);
        lock_make[1]  = lock_hit && !rel_d && (rx_byte == NUM_LOCK_CODE);
        lock_make[2]  = lock_hit && !rel_d && (rx_byte == SCROLL_LOCK_CODE);
        lock_break[0] = lock_hit &&  rel_d && (rx_byte == CAPS_LOCK_CODE);
        lock_break[1] = lock_hit &&  rel_d && (rx_byte == NUM_LOCK_CODE);
        lock_break[2] = lock_hit &&  rel_d && (rx_byte == SCROLL_LOCK_CODE);
    end

    ps2_lock_key u_caps (.clk(clk), .reset_low(reset_low), .make_i(lock_make[0]),
                         .break_i(lock_break[0]), .level_o(lock_level[0]), .toggle_o(lock_toggle[0]));
    ps2_lock_key u_num (.clk(clk), .reset_low(reset_low), .make_i(lock_make[1]),
                        .break_i(lock_break[1]), .level_o(lock_level[1]), .toggle_o(lock_toggle[1]));
    ps2_lock_key u_scroll (.clk(clk), .reset_low(reset_low), .make_i(lock_make[2]),
                           .break_i(lock_break[2]), .level_o(lock_level[2]), .toggle_o(lock_toggle[2]));

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q         <= SEQ_IDLE;
            skip_q          <= 3'd0;
            ack_q           <= 1'b0;
            resend_q        <= 1'b0;
            set_status_q    <= 1'b0;
            bat_error_q     <= 1'b0;
            receive_error_q <= 1'b0;
            key_valid_q     <= 1'b0;
            key_code_q      <= 8'h00;
            key_extended_q  <= 1'b0;
            key_release_q   <= 1'b0;
        end else begin
            ack_q           <= good && idle && (rx_byte == ACK);
            resend_q        <= good && idle && (rx_byte == RESEND);
            bat_error_q     <= good && idle && ((rx_byte == BAT_FAIL_0) || (rx_byte == BAT_FAIL_1));
            set_status_q    <= (good && idle && (rx_byte == BAT_OK)) || (|lock_toggle);
            receive_error_q <= accept && ps2.rx_error;

            if (event_d) begin
                key_valid_q    <= 1'b1;
                key_code_q     <= rx_byte;
                key_extended_q <= ext_d;
                key_release_q  <= rel_d;
            end else if (ps2.key_ready) begin
                key_valid_q    <= 1'b0;
            end

            if (accept) begin
                if (ps2.rx_error) begin
                    state_q <= SEQ_IDLE;
                    skip_q  <= 3'd0;
                end else begin
                    case (state_q)
                        SEQ_IDLE: begin
                            if (rx_byte == PREFIX_EXTENDED) begin
                                state_q <= SEQ_EXT;
                            end else if (rx_byte == PREFIX_BREAK) begin
                                state_q <= SEQ_BRK;
                            end else if (rx_byte == PREFIX_PAUSE) begin
                                state_q <= SEQ_SKIP;
                                skip_q  <= PAUSE_SKIP_COUNT;
                            end
                        end
                        SEQ_EXT: begin
                            state_q <= (rx_byte == PREFIX_BREAK) ? SEQ_EXT_BRK : SEQ_IDLE;
                        end
                        SEQ_SKIP: begin
                            skip_q <= skip_q - 3'd1;
                            if (skip_q <= 3'd1) begin
                                state_q <= SEQ_IDLE;
                            end
                        end
                        default: state_q <= SEQ_IDLE;
                    endcase
                end
            end
        end
    end

    assign ps2.acknowledge            = ack_q;
    assign ps2.resend                 = resend_q;
    assign ps2.set_status             = set_status_q;
    assign ps2.set_status_caps_lock   = lock_level[0];
    assign ps2.set_status_num_lock    = lock_level[1];
    assign ps2.set_status_scroll_lock = lock_level[2];
    assign ps2.bat_error              = bat_error_q;
    assign ps2.receive_error          = receive_error_q;
    assign ps2.key_valid              = key_valid_q;
    assign ps2.key_code               = key_code_q;
    assign ps2.key_extended           = key_extended_q;
    assign ps2.key_release            = key_release_q;
endmodule

// File: tb/tb_ps2_responses.sv
// tb/tb_ps2_responses.sv - directed and randomized bench for ps2_responses against a byte-stream model
module tb_ps2_responses;
    logic clk = 1'b0;
    logic reset_low = 1'b0;
    ps2_responses_if bus ();

    ps2_responses dut (.clk(clk), .reset_low(reset_low), .ps2(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ss_seen = 0;

    // Model: prefix flags, remaining Pause bytes, lock levels and held bits
    bit m_ext, m_brk;
    int m_skip;
    bit m_lvl [3];
    bit m_held [3];
    bit e_ack, e_resend, e_ss, e_bat, e_rxerr, e_ev, e_ext, e_rel;
    logic [7:0] e_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lock_idx(input logic [7:0] b);
        case (b)
            8'h58:   return 0;
            8'h77:   return 1;
            8'h7E:   return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0;
        for (int i = 0; i < 3; i++) begin
            m_lvl[i] = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic err);
        int k;
        e_ack = 0; e_resend = 0; e_ss = 0; e_bat = 0; e_rxerr = 0; e_ev = 0;
        if (err) begin
            e_rxerr = 1; m_ext = 0; m_brk = 0; m_skip = 0;
            return;
        end
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        if (!m_ext && !m_brk) begin
            case (b)
                8'hFA: begin e_ack = 1; return; end
                8'hFE: begin e_resend = 1; return; end
                8'hAA: begin e_ss = 1; return; end
                8'hFC, 8'hFD: begin e_bat = 1; return; end
                8'h00, 8'hFF: return;
                8'hE0: begin m_ext = 1; return; end
                8'hF0: begin m_brk = 1; return; end
                8'hE1: begin m_skip = 7; return; end
                default: ;
            endcase
        end else if (m_ext && !m_brk && b == 8'hF0) begin
            m_brk = 1;
            return;
        end
        e_ev = 1; e_code = b; e_ext = m_ext; e_rel = m_brk;
        m_ext = 0; m_brk = 0;
        k = lock_idx(b);
        if (!e_ext && k >= 0) begin
            if (e_rel) m_held[k] = 0;
            else if (!m_held[k]) begin
                m_lvl[k] = ~m_lvl[k];
                m_held[k] = 1;
                e_ss = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ack"}, bus.acknowledge, e_ack);
        chk({tag, ".resend"}, bus.resend, e_resend);
        chk({tag, ".set_status"}, bus.set_status, e_ss);
        chk({tag, ".bat_error"}, bus.bat_error, e_bat);
        chk({tag, ".receive_error"}, bus.receive_error, e_rxerr);
        chk({tag, ".key_valid"}, bus.key_valid, e_ev);
        if (e_ev) begin
            chk({tag, ".key_code"}, bus.key_code, e_code);
            chk({tag, ".key_extended"}, bus.key_extended, e_ext);
            chk({tag, ".key_release"}, bus.key_release, e_rel);
        end
        chk({tag, ".caps"}, bus.set_status_caps_lock, m_lvl[0]);
        chk({tag, ".num"}, bus.set_status_num_lock, m_lvl[1]);
        chk({tag, ".scroll"}, bus.set_status_scroll_lock, m_lvl[2]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_byte = b; bus.rx_error = err; bus.key_ready = 1'b1;
        model_byte(b, err);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        if (bus.set_status) ss_seen++;
        check_outputs($sformatf("byte_%02h", b));
        @(negedge clk);
        chk("pulse_width", {bus.acknowledge, bus.resend, bus.set_status, bus.bat_error,
                            bus.receive_error, bus.key_valid}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".pulses"}, {bus.acknowledge, bus.resend, bus.set_status, bus.bat_error,
                               bus.receive_error}, 32'd0);
        chk({tag, ".locks"}, {bus.set_status_caps_lock, bus.set_status_num_lock,
                              bus.set_status_scroll_lock}, 32'd0);
        chk({tag, ".key"}, {bus.key_valid, bus.key_code, bus.key_extended, bus.key_release}, 32'd0);
        chk({tag, ".rx_ready"}, bus.rx_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] resp [7];
        int ss_base;
        resp[0] = 8'hFA; resp[1] = 8'hFE; resp[2] = 8'hAA; resp[3] = 8'hFC;
        resp[4] = 8'hFD; resp[5] = 8'h00; resp[6] = 8'hFF;
        bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.rx_error = 1'b0; bus.key_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset_low = 1'b1;

        // Response strobes
        send_byte(8'hFA, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hFC, 1'b0);

        // Extended break held behind a stalled consumer
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_byte = 8'h75; bus.rx_error = 1'b0; bus.key_ready = 1'b0;
        model_byte(8'h75, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check_outputs("stall_event");
        chk("stall.rx_ready", bus.rx_ready, 1'b0);
        bus.rx_valid = 1'b1; bus.rx_byte = 8'h1C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.key_valid", bus.key_valid, 1'b1);
            chk("stall.key_code", bus.key_code, 8'h75);
            chk("stall.flags", {bus.key_extended, bus.key_release}, 2'b11);
            chk("stall.rx_ready", bus.rx_ready, 1'b0);
        end
        bus.rx_valid = 1'b0; bus.key_ready = 1'b1;
        @(negedge clk);
        chk("stall.release", bus.key_valid, 1'b0);

        // Take and new event in the same cycle
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_byte = 8'h1C;
        @(negedge clk);
        bus.rx_byte = 8'h32;
        chk("b2b.first", {bus.key_valid, bus.key_code}, {1'b1, 8'h1C});
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("b2b.second", {bus.key_valid, bus.key_code}, {1'b1, 8'h32});
        @(negedge clk);
        chk("b2b.drain", bus.key_valid, 1'b0);

        // Caps lock press, repeats, release, press
        ss_base = ss_seen;
        send_byte(8'h58, 1'b0);
        chk("caps.on", bus.set_status_caps_lock, 1'b1);
        send_byte(8'h58, 1'b0);
        send_byte(8'h58, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h58, 1'b0);
        send_byte(8'h58, 1'b0);
        chk("caps.off", bus.set_status_caps_lock, 1'b0);
        chk("caps.set_status_count", ss_seen - ss_base, 2);

        // Pause sequence yields nothing
        send_byte(8'hE1, 1'b0); send_byte(8'h14, 1'b0); send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0); send_byte(8'h77, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk("pause.after", {bus.set_status_num_lock}, 1'b0);

        // Errored byte aborts the extended prefix
        send_byte(8'hE0, 1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h1C, 1'b0);

        // Asynchronous reset mid-skip
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0); send_byte(8'h14, 1'b0); send_byte(8'hF0, 1'b0);
        @(negedge clk);
        #2 reset_low = 1'b0;
        #1 check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        reset_low = 1'b1;
        send_byte(8'h1C, 1'b0);

        // Randomized byte stream
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    rb = resp[$urandom_range(0, 6)];
                2:       rb = 8'hE0;
                3:       rb = 8'hF0;
                4:       rb = 8'hE1;
                5:       rb = 8'h58;
                6:       rb = ($urandom_range(0, 1) == 0) ? 8'h77 : 8'h7E;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            send_byte(rb, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_responses.md
# ps2_responses

Host-side interpreter for bytes received from a PS/2 keyboard; the receive counterpart of the command sequencer. It accepts decoded bytes from the PS/2 receiver and turns protocol responses into the single-cycle `acknowledge`, `resend` and `set_status` strobes the command sequencer consumes. It decodes set-2 make/break sequences into key events and owns the Caps/Num/Scroll lock state that drives the keyboard LEDs.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset_low` in 1: **asynchronous, active-low reset**.
- `rx_valid` in 1: received byte available.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready`.
- `rx_byte` in 8: received data byte.
- `rx_error` in 1: qualifies `rx_byte` as a parity/framing failure, sampled on acceptance.
- `acknowledge` out 1: pulse; device sent 0xFA.
- `resend` out 1: pulse; device sent 0xFE, so the host re-sends its last byte.
- `set_status` out 1: pulse; LED state must be (re)sent.
- `set_status_caps_lock`, `set_status_num_lock`, `set_status_scroll_lock` out 1 each: lock levels.
- `bat_error` out 1: pulse; device sent 0xFC or 0xFD.
- `receive_error` out 1: pulse; an errored byte was accepted.
- `key_valid` out 1: key event held.
- `key_ready` in 1: consumer takes the event when `key_valid && key_ready`.
- `key_code` out 8: set-2 scan code, without prefixes.
- `key_extended` out 1: the sequence carried 0xE0.
- `key_release` out 1: the sequence carried 0xF0.

## Operation
- Reset values: all pulses 0, all locks 0, `key_valid` 0, `key_code` 0x00, `key_extended` 0, `key_release` 0, state IDLE, skip counter 0.
- `rx_ready = !key_valid || key_ready`.
- Sequence states: IDLE, EXT (0xE0 seen), BRK (0xF0 seen), EXT_BRK (0xE0 then 0xF0 seen), SKIP.
- Response bytes, recognised only in IDLE:
  - 0xFA → `acknowledge`.
  - 0xFE → `resend`.
  - 0xAA (BAT passed) → `set_status`, which restores the LEDs after a keyboard self-reset.
  - 0xFC or 0xFD → `bat_error`.
  - 0x00 or 0xFF (overrun) → dropped silently.
- Prefix handling:
  - IDLE + 0xE0 → EXT.
  - IDLE + 0xF0 → BRK.
  - EXT + 0xF0 → EXT_BRK.
  - IDLE + 0xE1 → SKIP with counter 7. Each byte accepted in SKIP decrements the counter; the byte that reaches 0 returns to IDLE. The Pause sequence produces no key event.
- Any other byte in IDLE/EXT/BRK/EXT_BRK:
  - loads `key_code`, `key_extended` and `key_release` from the state;
  - sets `key_valid`;
  - returns the state to IDLE.
  - In EXT/BRK/EXT_BRK the response codes listed above are treated as ordinary scan codes.
- Lock keys: Caps = 0x58, Num = 0x77, Scroll = 0x7E. Only the non-extended codes count.
  - Each lock key keeps a `held` bit.
  - A make while not held toggles the lock level, sets held and pulses `set_status`.
  - A make while held (typematic repeat) does nothing to the lock.
  - A break clears held.
  - Lock keys are still reported as key events.
- Errored byte (`rx_error`=1 on acceptance):
  - pulses `receive_error`;
  - forces the state to IDLE and the skip counter to 0;
  - the byte is otherwise ignored.

## Timing
- All outputs are registered.
- Pulses are exactly one cycle wide, in the cycle after the accepting edge.
- `key_valid` rises in the cycle after the final byte is accepted.
- Latency: 1 cycle from the accepting edge.
- `key_code`, `key_extended` and `key_release` are stable while `key_valid && !key_ready`.
- Consumer take and new event in the same cycle: `key_valid` stays 1 and the fields are updated.
- Consumer take with no new event: `key_valid` → 0 next cycle.
- With `key_valid=1` and `key_ready=0`, `rx_ready=0` and no byte is consumed. Responses behind a stalled key are held off by the receiver.
- Asserting `reset_low` mid-sequence or mid-skip returns everything to reset values immediately, without waiting for a clock edge. A held key event is lost.

## Structure
- Shared package `ps2_package` holds:
  - the byte constants: ACK 0xFA, RESEND 0xFE, BAT_OK 0xAA, BAT_FAIL 0xFC/0xFD, PREFIX_EXTENDED 0xE0, PREFIX_PAUSE 0xE1, PREFIX_BREAK 0xF0;
  - the lock scan codes;
  - the sequence-state enum.
- The command sequencer's SET_STATUS (0xED) also moves into this package.
- One sub-module, `ps2_lock_key`, holds a lock level plus its held bit and emits a toggle strobe. It is instantiated three times; the three strobes are ORed into `set_status`.

## Test plan
- Byte 0xFA, then 0xFE, then 0xAA → one-cycle `acknowledge`, `resend`, `set_status` pulses respectively; no `key_valid`.
- Bytes E0 F0 75 → one event with `key_code`=0x75, `key_extended`=1, `key_release`=1; held with `key_ready`=0 while `rx_ready`=0.
- Bytes 58, 58, 58, F0 58, 58 → `set_status_caps_lock` goes 1 then 0, with exactly two `set_status` pulses and five key events.
- Bytes E1 14 77 E1 F0 14 F0 77, then 0x1C → no event for the Pause sequence; one event 0x1C with both flags 0.
- Byte E0, then 0x12 with `rx_error`=1, then 0x1C → `receive_error` pulse; event 0x1C with `key_extended`=0.
- `reset_low` low after F0 while the counter is mid-count → all outputs at reset values before the next clock edge; a following 0x1C decodes as a make code.
